// File: rtl/shift_tx_sequencer_if.sv
// Signal bundle between the word source, the sequencer, the 4-bit universal
// shift register and the downstream serial consumer.
//   master : sequencer side (drives handshake ready, register controls, tx line)
//   slave  : environment side (word source, register A_par[0], line consumer)
//   in_data/in_valid/in_ready          word handshake
//   s1/s0/I_par/MSB_in/LSB_in/A_lsb    shift register control and readback
//   tx_bit/tx_valid/frame_last/busy    serial line and status
interface shift_tx_sequencer_if;
  logic [3:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       s1;
  logic       s0;
  logic [3:0] I_par;
  logic       MSB_in;
  logic       LSB_in;
  logic       A_lsb;
  logic       tx_bit;
  logic       tx_valid;
  logic       frame_last;
  logic       busy;

  modport master (
    input  in_data, in_valid, A_lsb,
    output in_ready, s1, s0, I_par, MSB_in, LSB_in,
    output tx_bit, tx_valid, frame_last, busy
  );

  modport slave (
    output in_data, in_valid, A_lsb,
    input  in_ready, s1, s0, I_par, MSB_in, LSB_in,
    input  tx_bit, tx_valid, frame_last, busy
  );
endinterface

// File: rtl/shift_tx_sequencer.sv
// Upstream sequencer for a 4-bit universal shift register: accepts a word on
// a valid/ready handshake, parallel-loads it into the register, then shifts
// it right so A_par[0] presents the word LSB-first as a framed serial stream,
// followed by GAP_CYCLES idle cycles.
// Ports:
//   CLK      rising-edge clock
//   Clear_b  asynchronous active-low reset (shared with the shift register)
//   bus      shift_tx_sequencer_if.master (handshake, register controls, tx line)
// Parameters: GAP_CYCLES (0..15) idle cycles after each frame;
//             MSB_FILL serial-in value during shifts and idle line level.
// Optional feature: define SHIFT_TX_PARITY_EN to append an even-parity bit
// (frame of 5 bits, parity shifted in through MSB_in).
module shift_tx_sequencer #(
  parameter int unsigned GAP_CYCLES = 2,
  parameter logic        MSB_FILL   = 1'b1
) (
  input logic                  CLK,
  input logic                  Clear_b,
  shift_tx_sequencer_if.master bus
);

`ifdef SHIFT_TX_PARITY_EN
  localparam int unsigned NBITS = 5;
`else
  localparam int unsigned NBITS = 4;
`endif
  localparam int unsigned CNT_W = 3;
  localparam int unsigned GAP_W = 4;
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(NBITS - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] bit_cnt, bit_cnt_nxt;
  logic [GAP_W-1:0] gap_cnt, gap_cnt_nxt;
  logic             accept;

  logic [1:0] sel_q, sel_nxt;
  logic       in_ready_q, in_ready_nxt;
  logic       tx_valid_q, tx_valid_nxt;
  logic       frame_last_q, frame_last_nxt;
  logic       busy_q, busy_nxt;
  logic       msb_in_q, msb_in_nxt;
  logic [3:0] i_par_q, i_par_nxt;
`ifdef SHIFT_TX_PARITY_EN
  logic       par_q, par_nxt;
`endif

  assign accept = (state == IDLE) && bus.in_valid;

  // State, counters and registered outputs
  always_ff @(posedge CLK or negedge Clear_b) begin
    if (!Clear_b) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      gap_cnt      <= '0;
      sel_q        <= 2'b00;
      in_ready_q   <= 1'b1;
      tx_valid_q   <= 1'b0;
      frame_last_q <= 1'b0;
      busy_q       <= 1'b0;
      msb_in_q     <= MSB_FILL;
      i_par_q      <= '0;
`ifdef SHIFT_TX_PARITY_EN
      par_q        <= 1'b0;
`endif
    end else begin
      state        <= state_nxt;
      bit_cnt      <= bit_cnt_nxt;
      gap_cnt      <= gap_cnt_nxt;
      sel_q        <= sel_nxt;
      in_ready_q   <= in_ready_nxt;
      tx_valid_q   <= tx_valid_nxt;
      frame_last_q <= frame_last_nxt;
      busy_q       <= busy_nxt;
      msb_in_q     <= msb_in_nxt;
      i_par_q      <= i_par_nxt;
`ifdef SHIFT_TX_PARITY_EN
      par_q        <= par_nxt;
`endif
    end
  end

  // Next-state and counter logic
  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = '0;
    gap_cnt_nxt = '0;
    case (state)
      IDLE:  if (bus.in_valid) state_nxt = LOAD;
      LOAD:  state_nxt = SHIFT;
      SHIFT: begin
        bit_cnt_nxt = bit_cnt + CNT_W'(1);
        if (bit_cnt == BIT_LAST) state_nxt = (GAP_CYCLES == 0) ? IDLE : GAP;
      end
      GAP: begin
        gap_cnt_nxt = gap_cnt + GAP_W'(1);
        if (gap_cnt == GAP_LAST) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from the upcoming state so they are registered in step with it
  always_comb begin
    sel_nxt        = 2'b00;
    in_ready_nxt   = 1'b0;
    tx_valid_nxt   = 1'b0;
    frame_last_nxt = 1'b0;
    busy_nxt       = 1'b1;
    msb_in_nxt     = MSB_FILL;
    i_par_nxt      = i_par_q;
`ifdef SHIFT_TX_PARITY_EN
    par_nxt        = par_q;
    if (accept) par_nxt = ^bus.in_data;
`endif
    if (accept) i_par_nxt = bus.in_data;
    case (state_nxt)
      IDLE: begin
        in_ready_nxt = 1'b1;
        busy_nxt     = 1'b0;
      end
      LOAD: sel_nxt = 2'b11;
      SHIFT: begin
        sel_nxt        = 2'b01;
        tx_valid_nxt   = 1'b1;
        frame_last_nxt = (bit_cnt_nxt == BIT_LAST);
`ifdef SHIFT_TX_PARITY_EN
        // Parity enters at the MSB so it reaches A_par[0] after four shifts
        msb_in_nxt     = par_q;
`endif
      end
      default: sel_nxt = 2'b00;
    endcase
  end

  assign bus.s1         = sel_q[1];
  assign bus.s0         = sel_q[0];
  assign bus.in_ready   = in_ready_q;
  assign bus.tx_valid   = tx_valid_q;
  assign bus.frame_last = frame_last_q;
  assign bus.busy       = busy_q;
  assign bus.MSB_in     = msb_in_q;
  assign bus.LSB_in     = 1'b0;
  assign bus.I_par      = i_par_q;
  // Serial line passes the register output straight through during a frame
  assign bus.tx_bit     = tx_valid_q ? bus.A_lsb : MSB_FILL;

endmodule

// File: tb/tb_shift_tx_sequencer.sv
// Bench for shift_tx_sequencer: two instances (GAP_CYCLES=2 and 0) driven by
// the same word stream, each attached to a behavioural universal shift
// register, checked every cycle against a frame-template reference model.
module tb_shift_tx_sequencer;

`ifdef SHIFT_TX_PARITY_EN
  localparam int NB = 5;
`else
  localparam int NB = 4;
`endif
  localparam logic MSB_FILL = 1'b1;
  localparam int   GAP_A    = 2;
  localparam int   GAP_B    = 0;

  typedef struct packed {
    logic       txv;
    logic       txb;
    logic       last;
    logic [1:0] sel;
    logic       rdy;
    logic       busy;
    logic       msb;
  } exp_t;

  logic       CLK;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] in_data;
  logic [3:0] reg_a, reg_b;

  int n_checks = 0;
  int n_errors = 0;

  int         pos  [2];
  logic [3:0] word [2];
  logic [3:0] ipar_m [2];

  shift_tx_sequencer_if bus_a ();
  shift_tx_sequencer_if bus_b ();

  shift_tx_sequencer #(.GAP_CYCLES(GAP_A), .MSB_FILL(MSB_FILL)) dut_a (
    .CLK(CLK), .Clear_b(rst_n), .bus(bus_a.master));
  shift_tx_sequencer #(.GAP_CYCLES(GAP_B), .MSB_FILL(MSB_FILL)) dut_b (
    .CLK(CLK), .Clear_b(rst_n), .bus(bus_b.master));

  assign bus_a.in_valid = in_valid;
  assign bus_a.in_data  = in_data;
  assign bus_a.A_lsb    = reg_a[0];
  assign bus_b.in_valid = in_valid;
  assign bus_b.in_data  = in_data;
  assign bus_b.A_lsb    = reg_b[0];

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Universal shift registers: 00 hold, 01 right, 10 left, 11 load
  always @(posedge CLK or negedge rst_n) begin
    if (!rst_n) reg_a <= '0;
    else case ({bus_a.s1, bus_a.s0})
      2'b01:   reg_a <= {bus_a.MSB_in, reg_a[3:1]};
      2'b10:   reg_a <= {reg_a[2:0], bus_a.LSB_in};
      2'b11:   reg_a <= bus_a.I_par;
      default: reg_a <= reg_a;
    endcase
  end

  always @(posedge CLK or negedge rst_n) begin
    if (!rst_n) reg_b <= '0;
    else case ({bus_b.s1, bus_b.s0})
      2'b01:   reg_b <= {bus_b.MSB_in, reg_b[3:1]};
      2'b10:   reg_b <= {reg_b[2:0], bus_b.LSB_in};
      2'b11:   reg_b <= bus_b.I_par;
      default: reg_b <= reg_b;
    endcase
  end

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, expv, $time);
    end
  endtask

  // Expected outputs at position p of a frame (-1 = idle): 0 load, 1..NB bits, rest gap
  function automatic exp_t exp_at(input int p, input logic [3:0] w);
    exp_t e;
    int   k;
    logic b;
    e.txv = 1'b0; e.txb = MSB_FILL; e.last = 1'b0; e.sel = 2'b00;
    e.rdy = 1'b0; e.busy = 1'b1; e.msb = MSB_FILL;
    if (p < 0) begin
      e.rdy = 1'b1; e.busy = 1'b0;
    end else if (p == 0) begin
      e.sel = 2'b11;
    end else if (p <= NB) begin
      k = p - 1;
      b = (k < 4) ? w[k] : ^w;
      e.sel = 2'b01; e.txv = 1'b1; e.txb = b; e.last = (k == NB - 1);
      if (NB == 5) e.msb = ^w;
    end
    return e;
  endfunction

  function automatic int frame_len(input int i);
    return 1 + NB + ((i == 0) ? GAP_A : GAP_B);
  endfunction

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      if (rst_n) begin
        if (pos[i] >= 0) pos[i] = (pos[i] + 1 < frame_len(i)) ? pos[i] + 1 : -1;
        else if (in_valid) begin
          pos[i] = 0; word[i] = in_data; ipar_m[i] = in_data;
        end
      end
    end
  endtask

  task automatic cmp_dut(input string p, input exp_t e, input logic [3:0] ipe,
                         input logic txv, input logic txb, input logic last,
                         input logic s1, input logic s0, input logic rdy,
                         input logic busy, input logic msb, input logic lsb,
                         input logic [3:0] ipar);
    chk({p, "_tx_valid"},   8'(txv),      8'(e.txv));
    chk({p, "_tx_bit"},     8'(txb),      8'(e.txb));
    chk({p, "_frame_last"}, 8'(last),     8'(e.last));
    chk({p, "_sel"},        8'({s1, s0}), 8'(e.sel));
    chk({p, "_in_ready"},   8'(rdy),      8'(e.rdy));
    chk({p, "_busy"},       8'(busy),     8'(e.busy));
    chk({p, "_msb_in"},     8'(msb),      8'(e.msb));
    chk({p, "_lsb_in"},     8'(lsb),      8'(1'b0));
    chk({p, "_i_par"},      8'(ipar),     8'(ipe));
  endtask

  task automatic compare_all();
    cmp_dut("gap2", exp_at(pos[0], word[0]), ipar_m[0], bus_a.tx_valid, bus_a.tx_bit,
            bus_a.frame_last, bus_a.s1, bus_a.s0, bus_a.in_ready, bus_a.busy,
            bus_a.MSB_in, bus_a.LSB_in, bus_a.I_par);
    cmp_dut("gap0", exp_at(pos[1], word[1]), ipar_m[1], bus_b.tx_valid, bus_b.tx_bit,
            bus_b.frame_last, bus_b.s1, bus_b.s0, bus_b.in_ready, bus_b.busy,
            bus_b.MSB_in, bus_b.LSB_in, bus_b.I_par);
  endtask

  task automatic cycle(input logic v, input logic [3:0] d);
    @(negedge CLK);
    in_valid = v;
    in_data  = d;
    @(posedge CLK);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 4'($urandom));
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must fall back at once
  task automatic do_reset();
    @(negedge CLK);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    for (int i = 0; i < 2; i++) begin
      pos[i] = -1; ipar_m[i] = '0;
    end
    #1;
    compare_all();
    @(posedge CLK);
    #1;
    compare_all();
    @(negedge CLK);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    for (int i = 0; i < 2; i++) begin
      pos[i] = -1; word[i] = '0; ipar_m[i] = '0;
    end
    repeat (2) @(negedge CLK);
    #1;
    compare_all();
    rst_n = 1'b1;

    // Single word, one-cycle valid pulse
    cycle(1'b1, 4'b1010);
    idle(10);

    // Valid held high: 0xC then 0x3, data scrambled while the first frame is in flight
    for (int k = 0; k < 9; k++) begin
      if (k == 0)     cycle(1'b1, 4'hC);
      else if (k < 6) cycle(1'b1, 4'($urandom));
      else            cycle(1'b1, 4'h3);
    end
    idle(10);

    // Words whose parity differs (parity bit appended when enabled)
    cycle(1'b1, 4'b0111);
    idle(10);
    cycle(1'b1, 4'b0110);
    idle(10);

    // Reset during the second shift cycle, then a clean frame
    cycle(1'b1, 4'h9);
    cycle(1'b0, 4'h0);
    cycle(1'b0, 4'h0);
    do_reset();
    cycle(1'b1, 4'h5);
    idle(10);

    // Continuous valid: back-to-back frames, extra valids ignored mid-frame
    for (int k = 0; k < 30; k++) cycle(1'b1, 4'($urandom));
    idle(10);

    // Random traffic with occasional resets
    for (int k = 0; k < 500; k++) begin
      if ($urandom_range(0, 80) == 0) do_reset();
      else cycle(1'($urandom_range(0, 2) != 0), 4'($urandom));
    end
    idle(10);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
